debouncer_multi: RTL and testbench

//  Per-bit debouncer for NUM_CH independent inputs (buttons, switches, async status lines).

---
 rtl/debounce_pkg.sv | 28 ++
 rtl/debounce_channel.sv | 90 +++++++++
 rtl/debouncer_multi.sv | 82 ++++++++
 tb/tb_debouncer_multi.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared types and constants for the multi-channel debouncer.
//   Contents:
//     db_state_t     per-channel FSM state (DB_IDLE, DB_COUNT)
//     DB_SYNC_MAX    deepest synchroniser supported
//     sync_depth()   clamps a requested synchroniser depth to 1..DB_SYNC_MAX
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_t;

    localparam int DB_SYNC_MAX = 4;

    // Keeps the synchroniser array well formed even for an out-of-range depth.
    function automatic int sync_depth(input int n);
        if (n < 1)
            return 1;
        else if (n > DB_SYNC_MAX)
            return DB_SYNC_MAX;
        else
            return n;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One-bit debounce FSM with stability counter and registered edge pulses.
//   The input is expected to be already synchronised to clk.
//   Ports:
//     clk         clock
//     rst         synchronous active-high reset
//     en          1 = debounce active, 0 = FSM held in IDLE, output frozen
//     s           synchronised input level
//     thr_rise    stability threshold while counting toward 1
//     thr_fall    stability threshold while counting toward 0
//     data_out    debounced level (registered)
//     rise_pulse  1-cycle pulse in the cycle data_out goes 0->1
//     fall_pulse  1-cycle pulse in the cycle data_out goes 1->0
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   CNT_W   = 8,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic [CNT_W-1:0] thr_rise,
    input  logic [CNT_W-1:0] thr_fall,
    output logic             data_out,
    output logic             rise_pulse,
    output logic             fall_pulse
);

    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] thr;

    // Threshold follows the direction the channel is heading, sampled live.
    assign thr = s ? thr_rise : thr_fall;

    // NOTE: all state here is updated with <= so every register samples the
    // values from before the edge; blocking assignments would let data_out and
    // the pulses see each other's new values within the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DB_IDLE;
            cnt        <= '0;
            data_out   <= RST_VAL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (!en) begin
                state <= DB_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    DB_IDLE: begin
                        if (s != data_out) begin
                            cnt   <= '0;
                            state <= DB_COUNT;
                        end
                    end
                    DB_COUNT: begin
                        if (s == data_out) begin
                            // Input bounced back: abandon without touching the output.
                            cnt   <= '0;
                            state <= DB_IDLE;
                        end else if (cnt >= thr) begin
                            // >= rather than == so a threshold lowered mid-count
                            // still fires and cnt can never run past thr.
                            data_out   <= s;
                            rise_pulse <= s;
                            fall_pulse <= ~s;
                            cnt        <= '0;
                            state      <= DB_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= DB_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
//   Per-bit debouncer for NUM_CH independent, possibly asynchronous inputs.
//   Each channel: SYNC_STAGES-deep synchroniser -> debounce_channel FSM.
//   Ports:
//     clk          clock
//     rst          synchronous active-high reset
//     en           1 = debounce active, 0 = freeze outputs
//     stable_rise  threshold while a channel counts toward 1
//     stable_fall  threshold while a channel counts toward 0
//     data_in      raw inputs
//     data_out     debounced levels (registered)
//     rise_pulse   per-channel 1-cycle pulse on 0->1 of data_out
//     fall_pulse   per-channel 1-cycle pulse on 1->0 of data_out
//     any_change   registered OR of all pulses, one cycle after them
// -----------------------------------------------------------------------------
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int   NUM_CH      = 8,
    parameter int   CNT_W       = 8,
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  stable_rise,
    input  logic [CNT_W-1:0]  stable_fall,
    input  logic [NUM_CH-1:0] data_in,
    output logic [NUM_CH-1:0] data_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              any_change
);

    localparam int STAGES = sync_depth(SYNC_STAGES);

    logic [NUM_CH-1:0] sync_q [STAGES];
    logic [NUM_CH-1:0] s;

    // Synchroniser runs regardless of en so s is always current when en rises.
    // NOTE: this array is a few flip-flops rather than a RAM, so it is reset
    // like any other register and s starts from a defined value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++)
                sync_q[k] <= {NUM_CH{RST_VAL}};
        end else begin
            sync_q[0] <= data_in;
            for (int k = 1; k < STAGES; k++)
                sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[STAGES-1];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .CNT_W   (CNT_W),
            .RST_VAL (RST_VAL)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .s          (s[i]),
            .thr_rise   (stable_rise),
            .thr_fall   (stable_fall),
            .data_out   (data_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            any_change <= 1'b0;
        else
            any_change <= |(rise_pulse | fall_pulse);
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// -----------------------------------------------------------------------------
// tb_debouncer_multi
//   Directed bench for debouncer_multi (NUM_CH=8, SYNC_STAGES=2,
//   stable_rise=3, stable_fall=5 unless a scenario changes them).
//   Inputs are driven 1 time unit after a rising edge and outputs are sampled
//   at the same point, so "after n ticks" means "n edges after the change".
// -----------------------------------------------------------------------------
module tb_debouncer_multi;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [CNT_W-1:0]  stable_rise;
    logic [CNT_W-1:0]  stable_fall;
    logic [NUM_CH-1:0] data_in;
    logic [NUM_CH-1:0] data_out;
    logic [NUM_CH-1:0] rise_pulse;
    logic [NUM_CH-1:0] fall_pulse;
    logic              any_change;

    int n_pass  = 0;
    int n_total = 0;

    debouncer_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2),
        .RST_VAL     (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .stable_rise (stable_rise),
        .stable_fall (stable_fall),
        .data_in     (data_in),
        .data_out    (data_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .any_change  (any_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs n ticks and returns OR of every pulse/any_change/data_out bit seen.
    task automatic watch(input int n, output logic [NUM_CH-1:0] seen_out,
                         output logic [NUM_CH-1:0] seen_pulse, output logic seen_any);
        seen_out   = '0;
        seen_pulse = '0;
        seen_any   = 1'b0;
        repeat (n) begin
            tick();
            seen_out   |= data_out;
            seen_pulse |= rise_pulse | fall_pulse;
            seen_any   |= any_change;
        end
    endtask

    logic [NUM_CH-1:0] so, sp;
    logic              sa;
    int                glitch_len [3] = '{1, 2, 4};

    initial begin
        rst         = 1'b1;
        en          = 1'b1;
        stable_rise = 8'd3;
        stable_fall = 8'd5;
        data_in     = '0;
        tick(2);
        check("reset data_out", data_out, 8'h00);
        check("reset pulses", {rise_pulse, fall_pulse}, 16'h0000);
        check("reset any_change", any_change, 1'b0);
        rst = 1'b0;
        tick(3);

        // 1. Rise on ch0: output and pulse at tick 7, any_change at tick 8.
        data_in = 8'h01;
        tick(6);
        check("t1 data_out before", data_out, 8'h00);
        check("t1 rise before", rise_pulse, 8'h00);
        tick();
        check("t1 data_out at 7", data_out, 8'h01);
        check("t1 rise at 7", rise_pulse, 8'h01);
        check("t1 any_change at 7", any_change, 1'b0);
        tick();
        check("t1 rise at 8", rise_pulse, 8'h00);
        check("t1 any_change at 8", any_change, 1'b1);
        tick();
        check("t1 any_change at 9", any_change, 1'b0);

        // 2. Fall on ch0: output and pulse at tick 9.
        tick(2);
        data_in = 8'h00;
        tick(8);
        check("t2 data_out before", data_out, 8'h01);
        tick();
        check("t2 data_out at 9", data_out, 8'h00);
        check("t2 fall at 9", fall_pulse, 8'h01);
        check("t2 rise at 9", rise_pulse, 8'h00);
        tick();
        check("t2 fall at 10", fall_pulse, 8'h00);
        check("t2 any_change at 10", any_change, 1'b1);
        tick(3);

        // 3. Glitches on ch3 shorter than 5 cycles are rejected.
        foreach (glitch_len[g]) begin
            data_in = 8'h08;
            tick(glitch_len[g]);
            data_in = 8'h00;
            watch(14, so, sp, sa);
            check($sformatf("t3 glitch %0d data_out", glitch_len[g]), so, 8'h00);
            check($sformatf("t3 glitch %0d pulses", glitch_len[g]), {sp, 7'd0, sa}, 16'h0000);
        end
        // A 5-cycle pulse passes, then the fall is debounced at tick 14.
        data_in = 8'h08;
        tick(5);
        data_in = 8'h00;
        tick(2);
        check("t3 pulse5 data_out", data_out, 8'h08);
        check("t3 pulse5 rise", rise_pulse, 8'h08);
        tick(6);
        check("t3 pulse5 held", data_out, 8'h08);
        tick();
        check("t3 pulse5 fall data_out", data_out, 8'h00);
        check("t3 pulse5 fall", fall_pulse, 8'h08);
        tick(3);

        // 4. Simultaneous multi-channel rise, then fall.
        data_in = 8'hA5;
        tick(6);
        check("t4 data_out before", data_out, 8'h00);
        tick();
        check("t4 data_out", data_out, 8'hA5);
        check("t4 rise", rise_pulse, 8'hA5);
        tick();
        check("t4 rise cleared", rise_pulse, 8'h00);
        check("t4 any_change", any_change, 1'b1);
        data_in = 8'h00;
        tick(9);
        check("t4 fall", fall_pulse, 8'hA5);
        check("t4 data_out back", data_out, 8'h00);
        tick(3);

        // 5. en=0 mid-count freezes; en=1 restarts a full count (thr+2 = 5).
        data_in = 8'h01;
        tick(3);
        en = 1'b0;
        watch(10, so, sp, sa);
        check("t5 frozen data_out", so, 8'h00);
        check("t5 frozen pulses", sp, 8'h00);
        en = 1'b1;
        tick(4);
        check("t5 data_out before", data_out, 8'h00);
        tick();
        check("t5 data_out after en", data_out, 8'h01);
        check("t5 rise after en", rise_pulse, 8'h01);
        tick(2);
        // Zero thresholds: latency 2 + 0 + 2 = 4.
        stable_rise = 8'd0;
        stable_fall = 8'd0;
        data_in = 8'h00;
        tick(3);
        check("t5 thr0 before", data_out, 8'h01);
        tick();
        check("t5 thr0 data_out", data_out, 8'h00);
        check("t5 thr0 fall", fall_pulse, 8'h01);
        tick(2);

        // Maximum rise threshold: latency 2 + 255 + 2 = 259.
        stable_rise = 8'd255;
        stable_fall = 8'd5;
        data_in = 8'h80;
        tick(258);
        check("tmax before", data_out, 8'h00);
        tick();
        check("tmax data_out", data_out, 8'h80);
        check("tmax rise", rise_pulse, 8'h80);
        stable_rise = 8'd3;
        data_in = 8'h00;
        tick(9);
        check("tmax fall", fall_pulse, 8'h80);
        tick(3);

        // 6. Reset two cycles into a count from data_out=0xFF.
        data_in = 8'hFF;
        tick(7);
        check("t6 data_out ff", data_out, 8'hFF);
        tick(3);
        data_in = 8'h00;
        tick(4);
        check("t6 mid-count", data_out, 8'hFF);
        rst = 1'b1;
        tick();
        check("t6 reset data_out", data_out, 8'h00);
        check("t6 reset pulses", {rise_pulse, fall_pulse}, 16'h0000);
        check("t6 reset any_change", any_change, 1'b0);
        rst = 1'b0;
        watch(12, so, sp, sa);
        check("t6 after reset quiet", {so, sp}, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
